// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared pipeline definitions: arbiter FSM states and data-word width
package pipe_defs;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - counts consecutive denied host cycles, flags when the next count hits the limit
module arb_wait_counter #(
  parameter int LIMIT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       sat_next
);

  localparam logic [7:0] LIMIT_W = 8'(LIMIT);

  // cnt stays below LIMIT while counting, so cnt + 1 cannot wrap.
  assign sat_next = (cnt + 8'd1) == LIMIT_W;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (inc) cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// rtl/pipe_dmem_arbiter.sv - shares the data RAM between the MEM stage (priority) and a host port
module pipe_dmem_arbiter
  import pipe_defs::*;
#(
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t state, state_next;
  logic       cnt_clr, cnt_inc, sat_next;
  logic [7:0] wait_cnt;

  arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (wait_cnt),
    .sat_next (sat_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    host_gnt   = 1'b0;
    cpu_stall  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host_req) begin
          if (!cpu_req) begin
            host_gnt = 1'b1;
          end else begin
            cnt_inc    = 1'b1;
            state_next = sat_next ? ST_FORCE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!host_req) begin
          cnt_clr    = 1'b1;
          state_next = ST_IDLE;
        end else if (!cpu_req) begin
          host_gnt   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (sat_next) state_next = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // The stall freezes the pipeline so the CPU re-presents its access next cycle.
        host_gnt   = host_req;
        cpu_stall  = host_req;
        cnt_clr    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ram_we    = host_gnt ? host_we    : (cpu_we & cpu_req);
  assign ram_addr  = host_gnt ? host_addr  : cpu_addr;
  assign ram_wdata = host_gnt ? host_wdata : cpu_wdata;
  assign cpu_rdata = ram_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= ram_rdata;
    end
  end

endmodule
